// File: rtl/adc_frame_pusher.sv
// adc_frame_pusher
// Captures a packed multi-channel ADC frame and pushes the channels that are
// enabled in that frame's mask, sign-extended to 32 bits, into a FIFO push
// port. A one-deep pending slot absorbs a frame that arrives while busy. A
// third overlapping frame is dropped and counted.
// Optional feature: define ADC_FRAME_HDR_EN to precede each frame with a
// header word {8'hA5, seq[7:0], 16'(mask)}.
//
// state | meaning
// IDLE  | no active frame, push_valid low
// HDR   | presenting the header word of the active frame (ADC_FRAME_HDR_EN only)
// DATA  | presenting the lowest remaining enabled channel of the active frame
module adc_frame_pusher #(
    parameter int NCH    = 8,
    parameter int DATA_W = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  frame_valid_i,
    input  logic [NCH*DATA_W-1:0] frame_samples_packed_i,
    input  logic [NCH-1:0]        ch_mask_i,
    output logic                  push_valid_o,
    output logic [31:0]           push_data_o,
    input  logic                  push_ready_i,
    output logic                  busy_o,
    output logic                  pending_o,
    output logic                  frame_dropped_o,
    output logic [15:0]           drop_count_o,
    output logic [15:0]           frame_seq_o
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef ADC_FRAME_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [NCH*DATA_W-1:0]   act_samples_q, act_samples_d;
    logic [NCH-1:0]          rem_q, rem_d;
`ifdef ADC_FRAME_HDR_EN
    logic [NCH-1:0]          act_mask_q, act_mask_d;
    logic [7:0]              act_seq_q, act_seq_d;
`endif
    logic [NCH*DATA_W-1:0]   pend_samples_q, pend_samples_d;
    logic [NCH-1:0]          pend_mask_q, pend_mask_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [15:0]             frame_seq_q, frame_seq_d;
    logic [15:0]             drop_count_q, drop_count_d;
    logic                    frame_dropped_q, drop_d;

    logic [IDX_W-1:0]        sel_idx;
    logic [NCH-1:0]          rem_clr;
    logic signed [DATA_W-1:0] sel_sample;
    logic [31:0]             sel_word;
    logic                    xfer;
    logic                    frame_end;
    logic                    slot_free;
    logic                    load_en;
    logic [NCH*DATA_W-1:0]   src_samples;
    logic [NCH-1:0]          src_mask;

    // Lowest set bit of the remaining mask selects the channel on the bus.
    always_comb begin
        sel_idx = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (rem_q[c]) begin
                sel_idx = IDX_W'(c);
            end
        end
        rem_clr    = rem_q & ~(NCH'(1) << sel_idx);
        sel_sample = act_samples_q[int'(sel_idx)*DATA_W +: DATA_W];
        // Sized cast of a signed value sign-extends; DATA_W = 32 passes through.
        sel_word   = 32'(sel_sample);
    end

    // Output word mux; push_valid and busy are both "state is not IDLE".
    always_comb begin
        push_valid_o = (state_q != ST_IDLE);
        busy_o       = (state_q != ST_IDLE);
        push_data_o  = 32'h0;
        case (state_q)
            ST_DATA: push_data_o = sel_word;
`ifdef ADC_FRAME_HDR_EN
            ST_HDR:  push_data_o = {8'hA5, act_seq_q, 16'(act_mask_q)};
`endif
            default: push_data_o = 32'h0;
        endcase
    end

    assign xfer            = push_valid_o && push_ready_i;
    assign pending_o       = pend_valid_q;
    assign frame_dropped_o = frame_dropped_q;
    assign drop_count_o    = drop_count_q;
    assign frame_seq_o     = frame_seq_q;

    // Next-state: frame progress, active/pending slot management and drops.
    always_comb begin
        state_d        = state_q;
        act_samples_d  = act_samples_q;
        rem_d          = rem_q;
`ifdef ADC_FRAME_HDR_EN
        act_mask_d     = act_mask_q;
        act_seq_d      = act_seq_q;
`endif
        pend_samples_d = pend_samples_q;
        pend_mask_d    = pend_mask_q;
        pend_valid_d   = pend_valid_q;
        frame_seq_d    = frame_seq_q;
        drop_d         = 1'b0;
        frame_end      = 1'b0;
        load_en        = 1'b0;
        src_samples    = frame_samples_packed_i;
        src_mask       = ch_mask_i;

        case (state_q)
            ST_DATA: begin
                if (xfer) begin
                    rem_d     = rem_clr;
                    frame_end = (rem_clr == '0);
                end
            end
`ifdef ADC_FRAME_HDR_EN
            ST_HDR: begin
                if (xfer) begin
                    if (act_mask_q == '0) begin
                        frame_end = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
`endif
            default: ;
        endcase

        // The active slot is free in IDLE or on the final transfer of a frame;
        // pending always has priority so frames leave in arrival order.
        slot_free = (state_q == ST_IDLE) || frame_end;
        if (slot_free) begin
            if (pend_valid_q) begin
                load_en      = 1'b1;
                src_samples  = pend_samples_q;
                src_mask     = pend_mask_q;
                pend_valid_d = frame_valid_i;
                if (frame_valid_i) begin
                    pend_samples_d = frame_samples_packed_i;
                    pend_mask_d    = ch_mask_i;
                end
            end else if (frame_valid_i) begin
                load_en = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (frame_valid_i) begin
            if (!pend_valid_q) begin
                pend_valid_d   = 1'b1;
                pend_samples_d = frame_samples_packed_i;
                pend_mask_d    = ch_mask_i;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (load_en) begin
            act_samples_d = src_samples;
            rem_d         = src_mask;
            frame_seq_d   = frame_seq_q + 16'd1;
`ifdef ADC_FRAME_HDR_EN
            act_mask_d    = src_mask;
            act_seq_d     = frame_seq_q[7:0];
            state_d       = ST_HDR;
`else
            // A frame with nothing enabled produces no words at all.
            state_d       = (src_mask != '0) ? ST_DATA : ST_IDLE;
`endif
        end

        drop_count_d = drop_count_q;
        if (drop_d && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    // State and slot registers; reset clears everything, including pending.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            act_samples_q   <= '0;
            rem_q           <= '0;
`ifdef ADC_FRAME_HDR_EN
            act_mask_q      <= '0;
            act_seq_q       <= '0;
`endif
            pend_samples_q  <= '0;
            pend_mask_q     <= '0;
            pend_valid_q    <= 1'b0;
            frame_seq_q     <= '0;
            drop_count_q    <= '0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            act_samples_q   <= act_samples_d;
            rem_q           <= rem_d;
`ifdef ADC_FRAME_HDR_EN
            act_mask_q      <= act_mask_d;
            act_seq_q       <= act_seq_d;
`endif
            pend_samples_q  <= pend_samples_d;
            pend_mask_q     <= pend_mask_d;
            pend_valid_q    <= pend_valid_d;
            frame_seq_q     <= frame_seq_d;
            drop_count_q    <= drop_count_d;
            frame_dropped_q <= drop_d;
        end
    end

endmodule

// File: tb/tb_adc_frame_pusher.sv
// Directed bench for adc_frame_pusher (NCH=8, DATA_W=24). Expected words are
// queued when a frame is driven and checked as the DUT transfers them.
module tb_adc_frame_pusher;

    localparam int NCH = 8;
    localparam int DW  = 24;
`ifdef ADC_FRAME_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              frame_valid_i;
    logic [NCH*DW-1:0] frame_samples_packed_i;
    logic [NCH-1:0]    ch_mask_i;
    logic              push_valid_o;
    logic [31:0]       push_data_o;
    logic              push_ready_i;
    logic              busy_o;
    logic              pending_o;
    logic              frame_dropped_o;
    logic [15:0]       drop_count_o;
    logic [15:0]       frame_seq_o;

    adc_frame_pusher #(.NCH(NCH), .DATA_W(DW)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .frame_valid_i          (frame_valid_i),
        .frame_samples_packed_i (frame_samples_packed_i),
        .ch_mask_i              (ch_mask_i),
        .push_valid_o           (push_valid_o),
        .push_data_o            (push_data_o),
        .push_ready_i           (push_ready_i),
        .busy_o                 (busy_o),
        .pending_o              (pending_o),
        .frame_dropped_o        (frame_dropped_o),
        .drop_count_o           (drop_count_o),
        .frame_seq_o            (frame_seq_o)
    );

    always #5 clk_i = ~clk_i;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_seq = 16'h0;
    int          busy_cycles = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] sext24(input logic [23:0] s);
        return {{8{s[23]}}, s};
    endfunction

    function automatic logic [NCH*DW-1:0] rand_frame();
        logic [NCH*DW-1:0] v;
        for (int c = 0; c < NCH; c++) v[DW*c +: DW] = 24'($urandom);
        return v;
    endfunction

    task automatic expect_frame(input logic [NCH*DW-1:0] smp, input logic [NCH-1:0] m);
`ifdef ADC_FRAME_HDR_EN
        exp_q.push_back({8'hA5, exp_seq[7:0], 8'h00, m});
`endif
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) exp_q.push_back(sext24(smp[DW*c +: DW]));
        end
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [NCH*DW-1:0] smp, input logic [NCH-1:0] m,
                              input bit dropped);
        frame_valid_i          = 1'b1;
        frame_samples_packed_i = smp;
        ch_mask_i              = m;
        if (!dropped) expect_frame(smp, m);
        tick();
        frame_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!busy_o && !pending_o) break;
            tick();
        end
        check({tag, "_idle"}, {31'h0, busy_o}, 32'h0);
        check({tag, "_drained"}, exp_q.size(), 32'h0);
    endtask

    // Scoreboard monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk_i) begin
        logic [31:0] e;
        if (busy_o) busy_cycles++;
        if (stall_prev && !rst_i) begin
            check("stall_valid", {31'h0, push_valid_o}, 32'h1);
            check("stall_data", push_data_o, stall_data);
        end
        if (push_valid_o && push_ready_i && !rst_i) begin
            check("word_expected", {31'h0, exp_q.size() != 0}, 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("push_data", push_data_o, e);
            end
        end
        stall_prev = push_valid_o && !push_ready_i && !rst_i;
        stall_data = push_data_o;
    end

    initial begin
        logic [NCH*DW-1:0] smp;
        int len;

        rst_i                  = 1'b1;
        frame_valid_i          = 1'b0;
        frame_samples_packed_i = '0;
        ch_mask_i              = '0;
        push_ready_i           = 1'b1;
        #2;
        check("rst_push_valid", {31'h0, push_valid_o}, 32'h0);
        check("rst_push_data", push_data_o, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_pending", {31'h0, pending_o}, 32'h0);
        check("rst_dropped", {31'h0, frame_dropped_o}, 32'h0);
        check("rst_drop_count", {16'h0, drop_count_o}, 32'h0);
        check("rst_frame_seq", {16'h0, frame_seq_o}, 32'h0);
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Basic full mask, negative samples.
        for (int c = 0; c < NCH; c++) smp[DW*c +: DW] = 24'h800000 + 24'(c);
        busy_cycles = 0;
        send_frame(smp, 8'hFF, 1'b0);
        check("basic_latency_valid", {31'h0, push_valid_o}, 32'h1);
        check("basic_first_word", push_data_o, exp_q[0]);
        repeat (7 + HDR) tick();
        check("basic_busy_last", {31'h0, busy_o}, 32'h1);
        tick();
        check("basic_busy_after", {31'h0, busy_o}, 32'h0);
        wait_idle("basic");
        check("basic_busy_cycles", busy_cycles, 8 + HDR);
        check("basic_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});

        // Sparse mask with a 2-cycle stall mid-frame.
        send_frame(rand_frame(), 8'b1010_0100, 1'b0);
        tick();
        push_ready_i = 1'b0;
        tick();
        tick();
        push_ready_i = 1'b1;
        wait_idle("sparse");
        check("sparse_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});

        // Second frame arrives while busy: pending, then back-to-back.
        busy_cycles = 0;
        send_frame(rand_frame(), 8'hFF, 1'b0);
        send_frame(rand_frame(), 8'h0F, 1'b0);
        check("b2b_pending", {31'h0, pending_o}, 32'h1);
        check("b2b_no_drop", {31'h0, frame_dropped_o}, 32'h0);
        wait_idle("b2b");
        check("b2b_busy_cycles", busy_cycles, 12 + 2 * HDR);
        check("b2b_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});

        // Third overlapping frame is dropped, then drop_count saturates.
        push_ready_i = 1'b0;
        send_frame(rand_frame(), 8'hFF, 1'b0);
        send_frame(rand_frame(), 8'hFF, 1'b0);
        send_frame(rand_frame(), 8'h55, 1'b1);
        check("drop_pulse", {31'h0, frame_dropped_o}, 32'h1);
        check("drop_count_1", {16'h0, drop_count_o}, 32'h1);
        tick();
        check("drop_pulse_end", {31'h0, frame_dropped_o}, 32'h0);
        for (int i = 0; i < 65536; i++) send_frame(rand_frame(), 8'hFF, 1'b1);
        check("drop_sat", {16'h0, drop_count_o}, 32'h0000FFFF);
        check("drop_sat_pulse", {31'h0, frame_dropped_o}, 32'h1);
        push_ready_i = 1'b1;
        wait_idle("drop");
        check("drop_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});

        // New frame on the final transfer, pending empty: loaded directly.
        len = 2 + HDR;
        busy_cycles = 0;
        send_frame(rand_frame(), 8'h03, 1'b0);
        repeat (len - 1) tick();
        send_frame(rand_frame(), 8'h30, 1'b0);
        check("coinc_e_no_drop", {31'h0, frame_dropped_o}, 32'h0);
        check("coinc_e_pending", {31'h0, pending_o}, 32'h0);
        check("coinc_e_busy", {31'h0, busy_o}, 32'h1);
        wait_idle("coinc_e");
        check("coinc_e_busy_cycles", busy_cycles, 2 * len);

        // New frame on the final transfer, pending full: promote and capture.
        busy_cycles = 0;
        send_frame(rand_frame(), 8'h03, 1'b0);
        send_frame(rand_frame(), 8'h01, 1'b0);
        repeat (len - 2) tick();
        send_frame(rand_frame(), 8'h80, 1'b0);
        check("coinc_f_no_drop", {31'h0, frame_dropped_o}, 32'h0);
        check("coinc_f_pending", {31'h0, pending_o}, 32'h1);
        wait_idle("coinc_f");
        check("coinc_f_busy_cycles", busy_cycles, 4 + 3 * HDR);
        check("coinc_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});

        // Zero-mask frames, direct and via the pending slot.
        send_frame(rand_frame(), 8'h00, 1'b0);
        check("zero_busy", {31'h0, busy_o}, HDR);
        wait_idle("zero");
        check("zero_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});
        send_frame(rand_frame(), 8'hC1, 1'b0);
        send_frame(rand_frame(), 8'h00, 1'b0);
        wait_idle("zero_pend");
        check("zero_pend_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});

        // Asynchronous reset mid-frame with a pending frame held.
        push_ready_i = 1'b0;
        send_frame(rand_frame(), 8'hFF, 1'b0);
        send_frame(rand_frame(), 8'hFF, 1'b0);
        check("prereset_pending", {31'h0, pending_o}, 32'h1);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_push_valid", {31'h0, push_valid_o}, 32'h0);
        check("arst_push_data", push_data_o, 32'h0);
        check("arst_busy", {31'h0, busy_o}, 32'h0);
        check("arst_pending", {31'h0, pending_o}, 32'h0);
        check("arst_drop_count", {16'h0, drop_count_o}, 32'h0);
        check("arst_frame_seq", {16'h0, frame_seq_o}, 32'h0);
        exp_q.delete();
        exp_seq = 16'h0;
        tick();
        tick();
        rst_i        = 1'b0;
        push_ready_i = 1'b1;
        tick();
        send_frame(rand_frame(), 8'h81, 1'b0);
        wait_idle("post_rst");
        check("post_rst_frame_seq", {16'h0, frame_seq_o}, {16'h0, exp_seq});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
